// File: rtl/spi_master_rw16_if.sv
// Command, status and SPI pin bundle between the SPI master and its user/slave side.
interface spi_master_rw16_if;
  logic        start;
  logic        rw;
  logic [6:0]  addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic [15:0] rx_word;
  logic        ss_n;
  logic        sclk;
  logic        mosi;
  logic        miso;

  modport master (
    input  start, rw, addr, wdata, miso,
    output busy, done, rdata, rx_word, ss_n, sclk, mosi
  );

  modport slave (
    output start, rw, addr, wdata, miso,
    input  busy, done, rdata, rx_word, ss_n, sclk, mosi
  );
endinterface

// File: rtl/spi_master_rw16.sv
// SPI mode-0 master for 16-bit {rw,addr,data} frames, MSB first; done 1+SETUP_CYC+32*CLK_DIV+HOLD_CYC
// cycles after start; start is only sampled in IDLE, so requests while busy are dropped, never queued.
module spi_master_rw16 #(
  parameter int CLK_DIV   = 4,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_rw16_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic        ss_n_q, ss_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] rx_word_q, rx_word_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      ss_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      rx_word_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      ss_n_q    <= ss_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      rx_word_q <= rx_word_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    ss_n_d    = ss_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    rx_word_d = rx_word_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_d    = {bus.rw, bus.addr, bus.rw ? bus.wdata : 8'h00};
          ss_n_d  = 1'b0;
          mosi_d  = bus.rw;
          busy_d  = 1'b1;
          bit_d   = 4'd15;
          cnt_d   = '0;
          phase_d = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = XFER;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      XFER: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          if (!phase_q) begin
            sclk_d  = 1'b1;
            phase_d = 1'b1;
          end else begin
            // Last clk of the high phase: slave data is settled; mosi moves together with the sclk fall.
            rx_d    = {rx_q[14:0], bus.miso};
            sclk_d  = 1'b0;
            phase_d = 1'b0;
            if (bit_q == 4'd0) begin
              mosi_d  = 1'b0;
              state_d = HOLD;
            end else begin
              bit_d  = bit_q - 4'd1;
              mosi_d = tx_q[bit_q - 4'd1];
            end
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d     = '0;
          ss_n_d    = 1'b1;
          done_d    = 1'b1;
          rdata_d   = rx_q[7:0];
          rx_word_d = rx_q;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ss_n    = ss_n_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.rx_word = rx_word_q;

endmodule
